parking_gate_controller: RTL and testbench

//  Entry-gate sequencer and occupancy keeper for the parking lot. Consumes the single-cycle
//  car_enter/car_exit pulses from the a/b sensor FSM, runs the entry-gate handshake against

---
 rtl/parking_gate_controller.sv | 136 +++++++++++++
 tb/tb_parking_gate_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
// Entry-gate sequencer and lot occupancy keeper: grants or denies ticket requests,
// times out an unused open gate, and tracks count/full/err from sensor pulses.
module parking_gate_controller #(
    parameter int CAPACITY = 15,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 50,
    parameter int HOLD     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             car_enter,
    input  logic             car_exit,
    output logic             gate_open,
    output logic             grant,
    output logic             deny,
    output logic             timeout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             err
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam int HLD_W = $clog2(HOLD) + 1;

    typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [HLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               req_q;
    logic               gate_q, gate_d;
    logic               grant_q, grant_d;
    logic               deny_q, deny_d;
    logic               timeout_q, timeout_d;
    logic               err_q, err_d;
    logic               req_rise;
    logic               full_w;

    assign req_rise = entry_req & ~req_q;
    assign full_w   = (count_q == CNT_W'(CAPACITY));

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        hold_d    = hold_q;
        grant_d   = 1'b0;
        deny_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_rise) begin
                    if (full_w) begin
                        deny_d = 1'b1;
                    end else begin
                        state_d = OPEN;
                        timer_d = '0;
                        grant_d = 1'b1;
                    end
                end
            end
            OPEN: begin
                // A car entering on the last timer cycle still counts as a use, not a timeout.
                if (car_enter) begin
                    state_d = CLOSE;
                    hold_d  = '0;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d   = CLOSE;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            CLOSE: begin
                if (hold_q == HLD_W'(HOLD - 1)) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + HLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        gate_d = (state_d == OPEN);
    end

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (car_enter && !car_exit) begin
            if (full_w) err_d = 1'b1;
            else        count_d = count_q + CNT_W'(1);
        end else if (car_exit && !car_enter) begin
            if (count_q == '0) err_d = 1'b1;
            else               count_d = count_q - CNT_W'(1);
        end
        // Entry with the barrier not up is a tailgate: counted, but flagged.
        if (car_enter && state_q != OPEN) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            hold_q    <= '0;
            count_q   <= '0;
            req_q     <= 1'b1;
            gate_q    <= 1'b0;
            grant_q   <= 1'b0;
            deny_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
            req_q     <= entry_req;
            gate_q    <= gate_d;
            grant_q   <= grant_d;
            deny_q    <= deny_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign gate_open = gate_q;
    assign grant     = grant_q;
    assign deny      = deny_q;
    assign timeout   = timeout_q;
    assign count     = count_q;
    assign full      = full_w;
    assign err       = err_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: directed table, hand-written corner sequences,
// then randomized traffic compared against a cycle-count reference model.
module tb_parking_gate_controller;

    localparam int CAP  = 15;
    localparam int TMO  = 50;
    localparam int HLD  = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       entry_req, car_enter, car_exit;
    logic       gate_open, grant, deny, timeout, full, err;
    logic [3:0] count;

    int vectors = 0;
    int miscompares = 0;

    parking_gate_controller #(.CAPACITY(CAP), .CNT_W(4), .TIMEOUT(TMO), .HOLD(HLD)) dut (
        .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .car_enter(car_enter),
        .car_exit(car_exit), .gate_open(gate_open), .grant(grant), .deny(deny),
        .timeout(timeout), .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req, en, ex;
        logic [9:0] exp;   // {gate_open, grant, deny, timeout, count[3:0], full, err}
    } vec_t;

    vec_t tbl[12];

    function automatic logic [9:0] pk(input logic g, input logic gr, input logic d,
                                      input logic t, input logic [3:0] c,
                                      input logic f, input logic e);
        return {g, gr, d, t, c, f, e};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic x);
        entry_req = r;
        car_enter = e;
        car_exit  = x;
    endtask

    // Reference model: gate described by how long it has been up and how long the
    // lockout after closing still lasts; occupancy by plain integer arithmetic.
    int m_open_age;     // -1 when the barrier is down
    int m_lockout;      // cycles of post-close lockout remaining
    int m_count;
    bit m_err, m_prev_req, m_grant, m_deny, m_tmo;

    task automatic model_reset();
        m_open_age = -1; m_lockout = 0; m_count = 0;
        m_err = 0; m_prev_req = 1; m_grant = 0; m_deny = 0; m_tmo = 0;
    endtask

    task automatic model_step(input bit r, input bit e, input bit x);
        bit rise;
        int old_count;
        rise = r && !m_prev_req;
        m_prev_req = r;
        old_count = m_count;
        m_grant = 0; m_deny = 0; m_tmo = 0;
        if (e && !x) begin
            if (old_count == CAP) m_err = 1; else m_count = old_count + 1;
        end else if (x && !e) begin
            if (old_count == 0) m_err = 1; else m_count = old_count - 1;
        end
        if (e && m_open_age < 0) m_err = 1;
        if (m_open_age >= 0) begin
            if (e) begin
                m_open_age = -1; m_lockout = HLD;
            end else if (m_open_age == TMO - 1) begin
                m_open_age = -1; m_lockout = HLD; m_tmo = 1;
            end else begin
                m_open_age++;
            end
        end else if (m_lockout > 0) begin
            m_lockout--;
        end else if (rise) begin
            if (old_count == CAP) m_deny = 1;
            else begin m_grant = 1; m_open_age = 0; end
        end
    endtask

    function automatic logic [9:0] model_out();
        return pk(m_open_age >= 0, m_grant, m_deny, m_tmo, 4'(m_count), m_count == CAP, m_err);
    endfunction

    task automatic do_reset(input logic hold_req);
        drive(hold_req, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n_up;
        bit saw_tmo_early;
        logic tmo_at_drop;

        tbl[0]  = '{0, 0, 0, pk(0, 0, 0, 0, 4'd0, 0, 0)};
        tbl[1]  = '{1, 0, 0, pk(1, 1, 0, 0, 4'd0, 0, 0)};
        tbl[2]  = '{1, 0, 0, pk(1, 0, 0, 0, 4'd0, 0, 0)};
        tbl[3]  = '{1, 1, 0, pk(0, 0, 0, 0, 4'd1, 0, 0)};
        tbl[4]  = '{0, 0, 0, pk(0, 0, 0, 0, 4'd1, 0, 0)};
        tbl[5]  = '{1, 0, 0, pk(0, 0, 0, 0, 4'd1, 0, 0)};
        tbl[6]  = '{0, 0, 0, pk(0, 0, 0, 0, 4'd1, 0, 0)};
        tbl[7]  = '{0, 0, 0, pk(0, 0, 0, 0, 4'd1, 0, 0)};
        tbl[8]  = '{1, 0, 0, pk(1, 1, 0, 0, 4'd1, 0, 0)};
        tbl[9]  = '{0, 0, 1, pk(1, 0, 0, 0, 4'd0, 0, 0)};
        tbl[10] = '{0, 1, 1, pk(0, 0, 0, 0, 4'd0, 0, 0)};
        tbl[11] = '{0, 1, 0, pk(0, 0, 0, 0, 4'd1, 0, 1)};

        reset_n = 1'b0;
        drive(0, 0, 0);
        #12;
        chk("reset_state", pk(gate_open, grant, deny, timeout, count, full, err), 10'd0);
        #8 reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].req, tbl[i].en, tbl[i].ex);
            step();
            chk($sformatf("row%0d", i), pk(gate_open, grant, deny, timeout, count, full, err),
                tbl[i].exp);
        end

        // Async reset while the gate is up.
        drive(0, 0, 0);
        repeat (3) step();
        drive(1, 0, 0);
        step();
        chk("pre_reset_gate", gate_open, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_gate", gate_open, 0);
        chk("async_count", count, 0);
        chk("async_err", err, 0);

        // Request held through reset release is not a new request.
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_req_grant", grant, 0);
        end
        drive(0, 0, 0);
        step();
        drive(1, 0, 0);
        step();
        chk("rerise_grant", grant, 1);

        // Unused gate: open for exactly TIMEOUT cycles then a timeout pulse.
        drive(0, 0, 0);
        n_up = gate_open ? 1 : 0;
        saw_tmo_early = 0;
        tmo_at_drop = 0;
        for (int i = 0; i < TMO + 20; i++) begin
            step();
            if (!gate_open) begin
                tmo_at_drop = timeout;
                break;
            end
            n_up++;
            if (timeout) saw_tmo_early = 1;
        end
        chk("open_cycles", n_up, TMO);
        chk("timeout_pulse", tmo_at_drop, 1);
        chk("timeout_early", saw_tmo_early, 0);
        step();
        chk("timeout_one_cycle", timeout, 0);
        chk("timeout_count", count, 0);

        // Fill the lot, overflow, deny, then free a space and get a grant.
        drive(0, 1, 0);
        repeat (CAP) step();
        chk("fill_count", count, CAP);
        chk("fill_full", full, 1);
        step();
        chk("overflow_hold", count, CAP);
        drive(1, 0, 0);
        step();
        chk("full_deny", {deny, grant, gate_open}, 3'b100);
        step();
        chk("deny_one_cycle", deny, 0);
        drive(0, 0, 1);
        step();
        chk("exit_count", count, CAP - 1);
        chk("exit_full", full, 0);
        drive(1, 0, 0);
        step();
        chk("after_exit_grant", {grant, gate_open}, 2'b11);

        // Underflow at zero.
        do_reset(0);
        drive(0, 0, 1);
        step();
        chk("underflow", {count, err}, {4'd0, 1'b1});

        // Randomized traffic against the model.
        do_reset(0);
        for (int i = 0; i < 4000; i++) begin
            logic r, e, x;
            r = ($urandom % 4 == 0) ? ~entry_req : entry_req;
            e = ($urandom % 6 == 0);
            x = ($urandom % 7 == 0);
            drive(r, e, x);
            step();
            model_step(r, e, x);
            chk($sformatf("rand%0d", i), pk(gate_open, grant, deny, timeout, count, full, err),
                model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
